// File: rtl/led_anim_pkg.sv
// rtl/led_anim_pkg.sv - shared types for the LED animator
package led_anim_pkg;

  typedef enum logic [1:0] {
    MODE_SHIFT   = 2'd0,
    MODE_FILL    = 2'd1,
    MODE_BREATHE = 2'd2,
    MODE_BOUNCE  = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_DOWN = 1'b0,
    DIR_UP   = 1'b1
  } dir_e;

endpackage

// File: rtl/led_pwm.sv
// rtl/led_pwm.sv - free-running PWM; duty is sampled only at the period boundary
module led_pwm #(
  parameter int PWM_LEVELS = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(PWM_LEVELS)-1:0] duty,
  output logic                          pwm_out
);

  localparam int DW = $clog2(PWM_LEVELS);

  logic [DW-1:0] cnt_q;
  logic [DW-1:0] duty_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q  <= '0;
      duty_q <= '0;
    end else begin
      cnt_q <= cnt_q + 1'b1;
      // latching on the last count keeps every period a whole number of high clocks
      if (cnt_q == DW'(PWM_LEVELS - 1)) duty_q <= duty;
    end
  end

  assign pwm_out = (cnt_q < duty_q);

endmodule

// File: rtl/led_animator.sv
// rtl/led_animator.sv - LED pattern animator (shift/fill/breathe/bounce)
// Bounce mode is compiled only when LED_ANIMATOR_BOUNCE_EN is defined.
module led_animator #(
  parameter int N_LED      = 8,
  parameter int STEP_W     = 16,
  parameter int PWM_LEVELS = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        mode,
  input  logic              enable,
  input  logic [STEP_W-1:0] step_len,
  output logic [N_LED-1:0]  led_out,
  output logic              frame_done
);

  import led_anim_pkg::*;

  localparam int PW = $clog2(N_LED);
  localparam int DW = $clog2(PWM_LEVELS);
  localparam logic [PW-1:0]    POS_TOP  = PW'(N_LED - 1);
  localparam logic [DW-1:0]    DUTY_PEN = DW'(PWM_LEVELS - 2);
  localparam logic [N_LED-1:0] LED_ONE  = N_LED'(1);
  localparam logic [N_LED-1:0] LED_MSB  = LED_ONE << (N_LED - 1);
`ifdef LED_ANIMATOR_BOUNCE_EN
  localparam logic [PW-1:0]    POS_PEN  = PW'(N_LED - 2);
`endif

  mode_e             mode_in, mode_q, mode_d;
  logic [STEP_W-1:0] div_q, div_d, term;
  logic [PW-1:0]     pos_q, pos_d;
  dir_e              dir_q, dir_d;
  logic [DW-1:0]     duty_q, duty_d;
  logic              fill_q, fill_d;
  logic [N_LED-1:0]  led_q, led_d;
  logic              frame_q, frame_d;
  logic              mode_chg, run, tick, pwm;

  assign mode_in  = mode_e'(mode);
  assign term     = (step_len == '0) ? '0 : step_len - 1'b1;
  assign mode_chg = (mode_in != mode_q);
`ifdef LED_ANIMATOR_BOUNCE_EN
  assign run = enable && !mode_chg;
`else
  assign run = enable && !mode_chg && (mode_q != MODE_BOUNCE);
`endif
  // >= rather than == so a shortened step_len fires on the next enabled cycle
  assign tick = run && (div_q >= term);

  led_pwm #(.PWM_LEVELS(PWM_LEVELS)) u_pwm (
    .clk    (clk),
    .rst    (rst),
    .duty   (duty_q),
    .pwm_out(pwm)
  );

  always_comb begin
    mode_d  = mode_in;
    div_d   = div_q;
    pos_d   = pos_q;
    dir_d   = dir_q;
    duty_d  = duty_q;
    fill_d  = fill_q;
    led_d   = led_q;
    frame_d = 1'b0;
    if (mode_chg) begin
      div_d  = '0;
      pos_d  = POS_TOP;
      duty_d = '0;
      fill_d = 1'b0;
      led_d  = '0;
      dir_d  = (mode_in == MODE_BREATHE) ? DIR_UP : DIR_DOWN;
    end else if (run) begin
      div_d = tick ? '0 : div_q + 1'b1;
      case (mode_q)
        MODE_SHIFT: if (tick) begin
          if (led_q == '0 || led_q[0]) begin
            led_d   = LED_MSB;
            frame_d = led_q[0];
          end else begin
            led_d = led_q >> 1;
          end
        end
        MODE_FILL: if (tick) begin
          if (!fill_q) begin
            led_d  = {1'b1, led_q[N_LED-1:1]};
            fill_d = &led_q[N_LED-1:1];
          end else begin
            led_d = {1'b0, led_q[N_LED-1:1]};
            if (led_q[N_LED-1:1] == '0) begin
              fill_d  = 1'b0;
              frame_d = 1'b1;
            end
          end
        end
        MODE_BREATHE: begin
          led_d = pwm ? (LED_ONE << pos_q) : '0;
          if (tick) begin
            if (dir_q == DIR_UP) begin
              duty_d = duty_q + 1'b1;
              if (duty_q == DUTY_PEN) dir_d = DIR_DOWN;
            end else begin
              duty_d = duty_q - 1'b1;
              if (duty_q == DW'(1)) begin
                dir_d   = DIR_UP;
                pos_d   = (pos_q == '0) ? POS_TOP : pos_q - 1'b1;
                frame_d = (pos_q == '0);
              end
            end
          end
        end
`ifdef LED_ANIMATOR_BOUNCE_EN
        MODE_BOUNCE: if (tick) begin
          // first tick after a restart lights the top end without moving
          if (led_q == '0) begin
            led_d = LED_MSB;
          end else begin
            if (dir_q == DIR_DOWN) begin
              if (pos_q == '0) begin
                pos_d = PW'(1);
                if (POS_TOP == PW'(1)) frame_d = 1'b1;
                else dir_d = DIR_UP;
              end else begin
                pos_d = pos_q - 1'b1;
              end
            end else begin
              pos_d = pos_q + 1'b1;
              if (pos_q == POS_PEN) begin
                dir_d   = DIR_DOWN;
                frame_d = 1'b1;
              end
            end
            led_d = LED_ONE << pos_d;
          end
        end
`endif
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_q  <= MODE_SHIFT;
      div_q   <= '0;
      pos_q   <= POS_TOP;
      dir_q   <= DIR_DOWN;
      duty_q  <= '0;
      fill_q  <= 1'b0;
      led_q   <= '0;
      frame_q <= 1'b0;
    end else begin
      mode_q  <= mode_d;
      div_q   <= div_d;
      pos_q   <= pos_d;
      dir_q   <= dir_d;
      duty_q  <= duty_d;
      fill_q  <= fill_d;
      led_q   <= led_d;
      frame_q <= frame_d;
    end
  end

  assign led_out    = led_q;
  assign frame_done = frame_q;

endmodule

// File: tb/tb_led_animator.sv
// tb/tb_led_animator.sv - directed bench for led_animator (honours LED_ANIMATOR_BOUNCE_EN)
module tb_led_animator;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  mode;
  logic        enable;
  logic [15:0] step_len;
  logic [7:0]  led_out;
  logic        frame_done;

  int n_checks = 0;
  int n_pass   = 0;
  logic [7:0] exp_led;

  led_animator dut (
    .clk       (clk),
    .rst       (rst),
    .mode      (mode),
    .enable    (enable),
    .step_len  (step_len),
    .led_out   (led_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          sw;
    logic [1:0]  mode;
    logic [15:0] step;
    logic [7:0]  led;
    logic        fd;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(bit sw, logic [1:0] m, logic [15:0] s, logic [7:0] l, logic f);
    vec_t v;
    v.sw = sw; v.mode = m; v.step = s; v.led = l; v.fd = f;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic switch_mode(input logic [1:0] m, input logic [15:0] s);
    @(negedge clk);
    mode = m;
    step_len = s;
    @(negedge clk);
    check($sformatf("switch%0d_led", m), 32'(led_out), 32'h0);
    check($sformatf("switch%0d_fd", m), 32'(frame_done), 32'h0);
    exp_led = 8'h00;
  endtask

  task automatic step_expect(input string name, input int s, input logic [7:0] l, input logic f);
    for (int c = 1; c < s; c++) begin
      @(negedge clk);
      check({name, "_hold"}, 32'(led_out), 32'(exp_led));
      check({name, "_hold_fd"}, 32'(frame_done), 32'h0);
    end
    @(negedge clk);
    check(name, 32'(led_out), 32'(l));
    check({name, "_fd"}, 32'(frame_done), 32'(f));
    exp_led = l;
  endtask

  initial begin
    logic [7:0] l;
    int hi, exp_d, act_bit, stray;

    // FILL, step 2: full 16-tick frame
    l = 8'h00;
    for (int k = 0; k < 8; k++) begin l = {1'b1, l[7:1]}; add(k == 0, 2'd1, 16'd2, l, 1'b0); end
    for (int k = 0; k < 8; k++) begin l = {1'b0, l[7:1]}; add(1'b0, 2'd1, 16'd2, l, k == 7); end
    // SHIFT, step 4: one frame plus two steps, then FILL mid-frame
    l = 8'h80;
    add(1'b1, 2'd0, 16'd4, l, 1'b0);
    for (int k = 1; k < 8; k++) begin l = l >> 1; add(1'b0, 2'd0, 16'd4, l, 1'b0); end
    add(1'b0, 2'd0, 16'd4, 8'h80, 1'b1);
    add(1'b0, 2'd0, 16'd4, 8'h40, 1'b0);
    add(1'b0, 2'd0, 16'd4, 8'h20, 1'b0);
    add(1'b1, 2'd1, 16'd4, 8'h80, 1'b0);
    add(1'b0, 2'd1, 16'd4, 8'hC0, 1'b0);
    // BOUNCE, step 3
`ifdef LED_ANIMATOR_BOUNCE_EN
    for (int k = 0; k < 8; k++) add(k == 0, 2'd3, 16'd3, 8'h80 >> k, 1'b0);
    for (int k = 1; k < 8; k++) add(1'b0, 2'd3, 16'd3, 8'h01 << k, k == 7);
    add(1'b0, 2'd3, 16'd3, 8'h40, 1'b0);
`else
    for (int k = 0; k < 15; k++) add(k == 0, 2'd3, 16'd3, 8'h00, 1'b0);
`endif

    rst = 1'b1; mode = 2'd0; enable = 1'b1; step_len = 16'd2; exp_led = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_led", 32'(led_out), 32'h0);
    check("reset_fd", 32'(frame_done), 32'h0);
    rst = 1'b0;

    foreach (vecs[i]) begin
      if (vecs[i].sw) switch_mode(vecs[i].mode, vecs[i].step);
      step_expect($sformatf("vec%0d_m%0d", i, vecs[i].mode), int'(vecs[i].step), vecs[i].led, vecs[i].fd);
    end

    // freeze for 10 cycles right after a tick, then resume without skipping
    switch_mode(2'd0, 16'd4);
    step_expect("frz_a", 4, 8'h80, 1'b0);
    step_expect("frz_b", 4, 8'h40, 1'b0);
    step_expect("frz_c", 4, 8'h20, 1'b0);
    enable = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      check("freeze_led", 32'(led_out), 32'h20);
      check("freeze_fd", 32'(frame_done), 32'h0);
    end
    enable = 1'b1;
    step_expect("resume", 4, 8'h10, 1'b0);
    step_expect("resume2", 4, 8'h08, 1'b0);

    // shrink step_len below the running count: tick on the next cycle
    step_len = 16'd8;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("long_hold", 32'(led_out), 32'h08);
    end
    step_len = 16'd3;
    step_expect("shrink", 1, 8'h04, 1'b0);
    step_expect("shrink2", 3, 8'h02, 1'b0);

    // step_len 0 behaves as 1
    step_len = 16'd0;
    step_expect("step0_a", 1, 8'h01, 1'b0);
    step_expect("step0_b", 1, 8'h80, 1'b1);
    step_expect("step0_c", 1, 8'h40, 1'b0);

    // BREATHE: 2-period windows mid-step give 2*duty high clocks
    switch_mode(2'd2, 16'd64);
    hi = 0; stray = 0;
    for (int c = 1; c <= 64 * 32; c++) begin
      int k, off;
      @(negedge clk);
      k = c / 64;
      off = c % 64;
      act_bit = (k < 30) ? 7 : 6;
      if (off == 24) begin hi = 0; stray = 0; end
      if (off >= 24 && off < 56) begin
        hi += int'(led_out[act_bit]);
        if (((led_out & ~(8'h01 << act_bit)) != 8'h00) || frame_done) stray++;
      end
      if (off == 55) begin
        exp_d = (k <= 15) ? k : (k < 30) ? 30 - k : (k == 30) ? 0 : 1;
        check($sformatf("breathe_hi_k%0d", k), 32'(hi), 32'(2 * exp_d));
        check($sformatf("breathe_other_k%0d", k), 32'(stray), 32'h0);
      end
    end

    // asynchronous reset mid-animation, then restart of SHIFT
    switch_mode(2'd0, 16'd4);
    step_expect("prerst_a", 4, 8'h80, 1'b0);
    step_expect("prerst_b", 4, 8'h40, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_rst_led", 32'(led_out), 32'h0);
    check("async_rst_fd", 32'(frame_done), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    exp_led = 8'h00;
    step_expect("postrst", 4, 8'h80, 1'b0);
    l = 8'h80;
    for (int k = 1; k < 8; k++) begin
      l = l >> 1;
      step_expect($sformatf("postrst_%0d", k), 4, l, 1'b0);
    end

    // mode change on the edge that would wrap the frame: change wins
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check("prewrap_led", 32'(led_out), 32'h01);
    end
    switch_mode(2'd1, 16'd4);
    step_expect("wrap_fill", 4, 8'h80, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/led_animator.md
LED_ANIMATOR -- requirements
Module: led_animator

Interface
REQ-001 Parameter N_LED, default 8, number of LED outputs (≥2).
REQ-002 Parameter STEP_W, default 16, width of step-length input.
REQ-003 Parameter PWM_LEVELS, default 16, number of duty levels in breathe mode (power of 2, ≥4).
REQ-004 clk  input  1  clock, all logic on rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 mode  input  2  animation select: 0 SHIFT, 1 FILL, 2 BREATHE, 3 BOUNCE.
REQ-007 enable  input  1  high = animation advances; low = freeze.
REQ-008 step_len  input  STEP_W  clocks per animation step; 0 treated as 1.
REQ-009 led_out  output  N_LED  registered LED drive, bit N_LED-1 = leftmost.
REQ-010 frame_done  output  1  one-cycle pulse at end of each full animation cycle.

Function
REQ-011 Step tick: divider counts 0..step_len-1 while enable high, tick on terminal count, then wraps to 0.
REQ-012 enable low: divider, position, duty and led_out hold; no tick, frame_done low.
REQ-013 step_len changed mid-count: new value applies to the current count; if count ≥ new terminal, tick on the next enabled cycle.
REQ-014 Mode change: mode registered each cycle into mode_r; on mode != mode_r, next edge clears led_out, divider, position, duty and frame_done, and loads the new mode's initial state.
REQ-015 SHIFT: initial led_out=0; first tick lights bit N_LED-1; each tick shifts one position right; tick after bit 0 lit re-lights bit N_LED-1 and pulses frame_done.
REQ-016 FILL: each tick shifts right with 1 inserted at MSB until all ones (N_LED ticks), then shifts right with 0 inserted until all zero (N_LED ticks); frame_done pulses on reaching all zero; cycle = 2*N_LED ticks.
REQ-017 BREATHE: exactly one position active, starting at N_LED-1; all other bits 0.
REQ-018 BREATHE: active bit = PWM output; duty steps 0,1,..,PWM_LEVELS-1,..,1,0 one level per tick.
REQ-019 BREATHE: when duty returns to 0, position moves one right, wrapping 0 to N_LED-1; frame_done pulses at wrap.
REQ-020 PWM: free-running period PWM_LEVELS clocks; output high for duty clocks per period; duty 0 = constant low; duty updates only at period boundary (glitch-free).
REQ-021 BOUNCE: single lit bit moves N_LED-1 down to 0, then 1 up to N_LED-1, repeating; no end is lit twice in a row; frame_done pulses when returning to N_LED-1; cycle = 2*N_LED-2 ticks.
REQ-022 frame_done and a mode change on the same cycle: mode change wins, frame_done low.
REQ-023 led_out and frame_done change only on clk edges; no combinational path from inputs to outputs.

Reset
REQ-024 On rst: led_out=0, frame_done=0, mode_r=0, divider=0, duty=0, direction=down, position=N_LED-1.
REQ-025 rst asserted mid-animation aborts immediately; after release, the animation restarts from the initial state of the current mode input within 2 cycles.

Configuration
REQ-026 Macro LED_ANIMATOR_BOUNCE_EN: defined -> mode 3 runs BOUNCE per REQ-021.
REQ-027 Macro undefined -> no bounce logic compiled; mode 3 holds led_out=0 and frame_done=0, divider stopped.

Structure
REQ-028 Package led_anim_pkg holds the mode enum (SHIFT=0, FILL=1, BREATHE=2, BOUNCE=3) and the direction type.
REQ-029 One sub-module led_pwm (parameter PWM_LEVELS; ports clk, rst, duty, pwm_out), instantiated once.
REQ-030 Top-level state: mode_r, divider, position, direction, duty, fill phase; no other sub-modules.

Verification
REQ-031 N_LED=8, step_len=4, mode 0, enable=1 -> led_out 80,40,..,01,80 every 4 clocks; frame_done at the 01->80 tick.
REQ-032 mode 1, step_len=2 -> 80,C0,..,FF,7F,..,01,00 at 2-clock spacing; frame_done with 00; 16 ticks per frame.
REQ-033 mode 2, PWM_LEVELS=16, step_len=64 -> bit 7 high-time per 16-clock period = 0,1,..,15,..,1,0; then bit 6 active.
REQ-034 mode 0->1 switch mid-frame -> led_out=00 next cycle; first FILL pattern 80 one full step later; no frame_done pulse.
REQ-035 enable low 10 cycles mid-frame -> led_out constant; resume continues same sequence with no skipped step.
REQ-036 mode 3, macro defined -> 80..01..80, 14 ticks per frame; macro undefined -> led_out=00 constant.
